// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and the round-robin pick function for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {StIdle, StOwn} arb_state_e;

  localparam int unsigned DefNReq      = 4;
  localparam int unsigned DefFifoWidth = 16;
  localparam int unsigned DefMaxBurst  = 8;
  localparam int unsigned MaxReq       = 8;

  // First asserted request at or after ptr, wrapping modulo n; returns one-hot.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                 input logic [2:0]        ptr,
                                                 input int unsigned       n);
    logic [MaxReq-1:0] gnt;
    logic [2:0]        idx;
    gnt = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < n) begin
        idx = 3'((32'(ptr) + k) % n);
        if (req[idx] && (gnt == '0)) begin
          gnt[idx] = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO write-side signals of the arbiter. Stats ports exist only when
// FIFO_WR_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned FIFO_WIDTH = 16
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ*FIFO_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            grant;
  logic [FIFO_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_wr_en;
  logic                        fifo_full;
  logic                        fifo_almostfull;
  logic                        fifo_wr_ack;
  logic                        fifo_overflow;
  logic                        ack_err;
  logic                        ovf_err;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]                 stat_words;
  logic [15:0]                 stat_stalls;

  modport master (
    input  req, req_last, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output grant, fifo_data_in, fifo_wr_en, ack_err, ovf_err, stat_words, stat_stalls
  );
  modport slave (
    output req, req_last, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  grant, fifo_data_in, fifo_wr_en, ack_err, ovf_err, stat_words, stat_stalls
  );
`else
  modport master (
    input  req, req_last, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output grant, fifo_data_in, fifo_wr_en, ack_err, ovf_err
  );
  modport slave (
    output req, req_last, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  grant, fifo_data_in, fifo_wr_en, ack_err, ovf_err
  );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate: one-hot grant to the first request at or after ptr_i.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o
);

  logic [MaxReq-1:0] req_pad;
  logic [MaxReq-1:0] pick;

  assign req_pad = MaxReq'(req_i);
  assign pick    = rr_pick(req_pad, 3'(ptr_i), N_REQ);
  assign gnt_o   = pick[N_REQ-1:0];

  if (N_REQ < MaxReq) begin : g_pad
    logic unused_pick;
    assign unused_pick = ^pick[MaxReq-1:N_REQ];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the FIFO write port with ack/overflow checking.
// Optional FIFO_WR_ARB_STATS_EN adds saturating word and stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = DefNReq,
  parameter int unsigned FIFO_WIDTH = DefFifoWidth,
  parameter int unsigned MAX_BURST  = DefMaxBurst
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus_io
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d, cnt_inc;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, exp_ack_q, ack_err_q, ovf_err_q;
  logic                  throttle, xfer;
  logic [N_REQ-1:0]      rr_gnt, grant;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (32'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // almostfull alone is not enough: the write already issued will take the last slot.
  assign throttle = bus_io.fifo_full || (bus_io.fifo_almostfull && wr_en_q);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i (bus_io.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  always_comb begin
    grant = '0;
    if (!rst && !throttle) begin
      unique case (state_q)
        StIdle: grant = rr_gnt;
        StOwn:  if (bus_io.req[owner_q]) grant[owner_q] = 1'b1;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel = PtrW'(i);
    end
  end

  assign xfer    = |grant;
  assign cnt_inc = burst_cnt_q + 1'b1;
  assign data_d  = xfer ? bus_io.req_data[sel*FIFO_WIDTH +: FIFO_WIDTH] : data_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (bus_io.req_last[sel] || (MAX_BURST == 32'd1)) begin
            rr_ptr_d = inc_ptr(sel);
          end else begin
            state_d     = StOwn;
            owner_d     = sel;
            burst_cnt_d = CntW'(1);
          end
        end
      end
      StOwn: begin
        if (!bus_io.req[owner_q]) begin
          state_d     = StIdle;
          rr_ptr_d    = inc_ptr(owner_q);
          burst_cnt_d = '0;
        end else if (xfer) begin
          if (bus_io.req_last[owner_q] || (32'(cnt_inc) >= MAX_BURST)) begin
            state_d     = StIdle;
            rr_ptr_d    = inc_ptr(owner_q);
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      exp_ack_q   <= 1'b0;
      ack_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      data_q      <= data_d;
      wr_en_q     <= xfer;
      exp_ack_q   <= wr_en_q;
      ack_err_q   <= exp_ack_q && !bus_io.fifo_wr_ack;
      ovf_err_q   <= bus_io.fifo_overflow;
    end
  end

  assign bus_io.grant        = grant;
  assign bus_io.fifo_data_in = data_q;
  assign bus_io.fifo_wr_en   = wr_en_q;
  assign bus_io.ack_err      = ack_err_q;
  assign bus_io.ovf_err      = ovf_err_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_words_q, stat_stalls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (wr_en_q && (stat_words_q != 16'hFFFF)) stat_words_q <= stat_words_q + 16'd1;
      if ((|bus_io.req) && throttle && (stat_stalls_q != 16'hFFFF)) begin
        stat_stalls_q <= stat_stalls_q + 16'd1;
      end
    end
  end

  assign bus_io.stat_words  = stat_words_q;
  assign bus_io.stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, FIFO_WIDTH=16, MAX_BURST=8).
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic drop_ack = 1'b0;
  int   n_asserts = 0;
  int   n_fail = 0;

  fifo_wr_arbiter_if #(.N_REQ(4), .FIFO_WIDTH(16)) ifc ();

  fifo_wr_arbiter #(.N_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifc)
  );

  always #5 clk = ~clk;

  // FIFO model: acks each write one cycle after wr_en unless told to drop it.
  always @(posedge clk or posedge rst) begin
    if (rst) ifc.fifo_wr_ack <= 1'b0;
    else     ifc.fifo_wr_ack <= ifc.fifo_wr_en && !drop_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    ifc.req_data[i*16 +: 16] = w;
  endtask

  initial begin
    ifc.req = '0;
    ifc.req_last = '0;
    ifc.req_data = '0;
    ifc.fifo_full = 1'b0;
    ifc.fifo_almostfull = 1'b0;
    ifc.fifo_overflow = 1'b0;
    for (int i = 0; i < 4; i++) set_word(i, 16'(16'hB0 + i));
    #1 rst = 1'b1;
    #2;
    chk("rst_grant", 32'(ifc.grant), 32'h0);
    chk("rst_wr_en", 32'(ifc.fifo_wr_en), 32'h0);
    chk("rst_data", 32'(ifc.fifo_data_in), 32'h0);
    chk("rst_ack_err", 32'(ifc.ack_err), 32'h0);
    chk("rst_ovf_err", 32'(ifc.ovf_err), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Single requester, 3-word burst.
    ifc.req = 4'b0001;
    set_word(0, 16'hA1);
    #1 chk("t1_grant_a1", 32'(ifc.grant), 32'h1);
    tick();
    chk("t1_data_a1", 32'(ifc.fifo_data_in), 32'hA1);
    chk("t1_wr_en_a1", 32'(ifc.fifo_wr_en), 32'h1);
    set_word(0, 16'hA2);
    #1 chk("t1_grant_a2", 32'(ifc.grant), 32'h1);
    tick();
    chk("t1_data_a2", 32'(ifc.fifo_data_in), 32'hA2);
    set_word(0, 16'hA3);
    ifc.req_last = 4'b0001;
    #1 chk("t1_grant_a3", 32'(ifc.grant), 32'h1);
    tick();
    chk("t1_data_a3", 32'(ifc.fifo_data_in), 32'hA3);
    chk("t1_wr_en_a3", 32'(ifc.fifo_wr_en), 32'h1);
    ifc.req = '0;
    ifc.req_last = '0;
    set_word(0, 16'hB0);
    #1 chk("t1_grant_idle", 32'(ifc.grant), 32'h0);
    tick();
    chk("t1_wr_en_off", 32'(ifc.fifo_wr_en), 32'h0);
    chk("t1_data_hold", 32'(ifc.fifo_data_in), 32'hA3);
    chk("t1_ack_err", 32'(ifc.ack_err), 32'h0);

    // rr_ptr is 1: requesters 0 and 3 pending, 3 wins; pointer wraps to 0.
    ifc.req = 4'b1001;
    ifc.req_last = 4'b1111;
    #1 chk("ptr_grant3", 32'(ifc.grant), 32'h8);
    tick();
    chk("ptr_data3", 32'(ifc.fifo_data_in), 32'hB3);

    // All requesting single words: 0,1,2,3,0.
    ifc.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr_grant_%0d", k), 32'(ifc.grant), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr_data_%0d", k), 32'(ifc.fifo_data_in), 32'(16'hB0 + (k % 4)));
      chk($sformatf("rr_wr_en_%0d", k), 32'(ifc.fifo_wr_en), 32'h1);
    end

    // Requester 2 long burst capped at 8, requester 3 pending.
    ifc.req = 4'b1100;
    ifc.req_last = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      set_word(2, 16'(16'hC00 + k));
      #1 chk($sformatf("burst_grant_%0d", k), 32'(ifc.grant), 32'h4);
      tick();
      chk($sformatf("burst_data_%0d", k), 32'(ifc.fifo_data_in), 32'(16'hC00 + k));
    end
    #1 chk("burst_release_g3", 32'(ifc.grant), 32'h8);
    tick();
    chk("burst_data3", 32'(ifc.fifo_data_in), 32'hB3);
    ifc.req = 4'b0100;
    for (int k = 8; k < 12; k++) begin
      set_word(2, 16'(16'hC00 + k));
      ifc.req_last = (k == 11) ? 4'b0100 : 4'b0000;
      #1 chk($sformatf("burst_resume_%0d", k), 32'(ifc.grant), 32'h4);
      tick();
    end
    chk("burst_last_data", 32'(ifc.fifo_data_in), 32'hC0B);
    ifc.req = '0;
    ifc.req_last = '0;

    // Backpressure: almostfull with a write in flight, then full for 5 cycles.
    ifc.req = 4'b0001;
    ifc.req_last = 4'b0001;
    #1 chk("thr_grant_pre", 32'(ifc.grant), 32'h1);
    tick();
    ifc.fifo_almostfull = 1'b1;
    #1 chk("thr_af_inflight", 32'(ifc.grant), 32'h0);
    tick();
    chk("thr_wr_en_off", 32'(ifc.fifo_wr_en), 32'h0);
    chk("thr_af_idle", 32'(ifc.grant), 32'h1);
    ifc.fifo_full = 1'b1;
    #1 chk("thr_full", 32'(ifc.grant), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("full_wr_en_%0d", k), 32'(ifc.fifo_wr_en), 32'h0);
      chk($sformatf("full_grant_%0d", k), 32'(ifc.grant), 32'h0);
      chk($sformatf("full_ovf_%0d", k), 32'(ifc.ovf_err), 32'h0);
    end
    ifc.fifo_full = 1'b0;
    ifc.fifo_almostfull = 1'b0;
    ifc.req = '0;
    ifc.req_last = '0;

    // Missing ack, then a forced overflow.
    ifc.req = 4'b0001;
    ifc.req_last = 4'b0001;
    #1 chk("ack_grant", 32'(ifc.grant), 32'h1);
    tick();
    ifc.req = '0;
    drop_ack = 1'b1;
    tick();
    drop_ack = 1'b0;
    chk("ack_err_early", 32'(ifc.ack_err), 32'h0);
    tick();
    chk("ack_err_pulse", 32'(ifc.ack_err), 32'h1);
    tick();
    chk("ack_err_clear", 32'(ifc.ack_err), 32'h0);
    ifc.fifo_overflow = 1'b1;
    #1 chk("ovf_err_early", 32'(ifc.ovf_err), 32'h0);
    tick();
    ifc.fifo_overflow = 1'b0;
    chk("ovf_err_pulse", 32'(ifc.ovf_err), 32'h1);
    tick();
    chk("ovf_err_clear", 32'(ifc.ovf_err), 32'h0);

    // Reset mid-burst in OWN.
    ifc.req = 4'b0010;
    ifc.req_last = '0;
    #1 chk("mid_grant", 32'(ifc.grant), 32'h2);
    tick();
    tick();
    chk("mid_wr_en", 32'(ifc.fifo_wr_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(ifc.fifo_wr_en), 32'h0);
    chk("mid_rst_data", 32'(ifc.fifo_data_in), 32'h0);
    chk("mid_rst_grant", 32'(ifc.grant), 32'h0);
    ifc.req = 4'b1111;
    ifc.req_last = 4'b1111;
    #1 rst = 1'b0;
    #1 chk("post_rst_grant", 32'(ifc.grant), 32'h1);
    tick();
    chk("post_rst_data", 32'(ifc.fifo_data_in), 32'hB0);
    chk("post_rst_wr_en", 32'(ifc.fifo_wr_en), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
